// File: rtl/winograd_pkg.sv
// Shared definitions for the Winograd processing element.
// Contents:
//   mode_e         - tile mode (6x6 or 4x4 / F(4,3))
//   *_tile_t       - 6x6 tile types at the default element widths
//   AT_COEF        - output-transform matrix AT (entry [3][5] is the latched mode)
//   sat()          - clamp a wide signed value to a given signed width
//   at_row()       - one row of AT applied to a 6-element vector, shifts/adds only
package winograd_pkg;

  typedef enum logic {
    MODE_6X6 = 1'b0,
    MODE_4X4 = 1'b1
  } mode_e;

  localparam int TILE_N       = 6;
  localparam int DEF_DATA_W   = 14;
  localparam int DEF_WEIGHT_W = 12;
  localparam int DEF_OUT_W    = 16;

  typedef logic [TILE_N-1:0][TILE_N-1:0][DEF_DATA_W-1:0]   data_tile_t;
  typedef logic [TILE_N-1:0][TILE_N-1:0][DEF_WEIGHT_W-1:0] weight_tile_t;
  typedef logic [TILE_N-1:0][TILE_N-1:0][DEF_OUT_W-1:0]    result_tile_t;

  // Reference copy of AT; the [3][5] entry is replaced by the latched mode bit.
  localparam int AT_COEF [TILE_N][TILE_N] = '{
    '{1, 1,  1,  1,   1, 0},
    '{0, 1, -1,  2,  -2, 0},
    '{0, 1,  1,  4,   4, 0},
    '{0, 1, -1,  8,  -8, 0},
    '{0, 1,  1, 16,  16, 0},
    '{0, 1, -1, 32, -32, 1}
  };

  typedef logic signed [63:0] wide_t;
  typedef logic [TILE_N-1:0][63:0] vec6_t;

  function automatic wide_t sat(input wide_t v, input int w);
    wide_t hi;
    wide_t lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  // Row r of AT has the shape a1 +/- a2 + 2^r*(a3 +/- a4), with the sign
  // alternating by row parity, so the whole transform is shifts and adds.
  function automatic wide_t at_row(input vec6_t v, input int r, input logic m);
    wide_t a0, a1, a2, a3, a4, a5, res;
    a0 = $signed(v[0]);
    a1 = $signed(v[1]);
    a2 = $signed(v[2]);
    a3 = $signed(v[3]);
    a4 = $signed(v[4]);
    a5 = $signed(v[5]);
    if (r == 0)
      res = a0 + a1 + a2 + a3 + a4;
    else if (r % 2 == 0)
      res = a1 + a2 + ((a3 + a4) <<< r);
    else
      res = a1 - a2 + ((a3 - a4) <<< r);
    if (r == 5 || (r == 3 && m))
      res = res + a5;
    return res;
  endfunction

endpackage

// File: rtl/winograd_out_fifo.sv
// Show-ahead output FIFO holding finished result tiles and their addresses.
// Ports:
//   clk, reset           - clock, asynchronous active-high reset
//   push, push_tile,
//   push_addr            - write side; a push while full without a pop is dropped
//   pop_ready            - consumer takes the head when head_valid is high
//   head_tile, head_addr,
//   head_valid           - current head, all zero when empty
//   overflow             - sticky flag, set when a tile has been dropped
module winograd_out_fifo
  import winograd_pkg::*;
#(
  parameter int ELEM_W     = 16,
  parameter int ADDR_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          push,
  input  logic [5:0][5:0][ELEM_W-1:0]   push_tile,
  input  logic [ADDR_W-1:0]             push_addr,
  input  logic                          pop_ready,
  output logic [5:0][5:0][ELEM_W-1:0]   head_tile,
  output logic [ADDR_W-1:0]             head_addr,
  output logic                          head_valid,
  output logic                          overflow
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  logic [5:0][5:0][ELEM_W-1:0] tile_mem [FIFO_DEPTH];
  logic [ADDR_W-1:0]           addr_mem [FIFO_DEPTH];
  logic [PTR_W:0]              wr_ptr;
  logic [PTR_W:0]              rd_ptr;
  logic [PTR_W:0]              count;
  logic                        full;
  logic                        empty;
  logic                        pop;
  logic                        do_push;

  // The extra pointer bit makes count reach FIFO_DEPTH when full instead of wrapping to 0.
  assign count   = wr_ptr - rd_ptr;
  assign empty   = (count == '0);
  assign full    = (count == (PTR_W + 1)'(FIFO_DEPTH));
  assign pop     = !empty && pop_ready;
  // A pop in the same cycle frees the slot, so a push while full still lands.
  assign do_push = push && (!full || pop);

  assign head_valid = !empty;
  assign head_tile  = empty ? '0 : tile_mem[rd_ptr[PTR_W-1:0]];
  assign head_addr  = empty ? '0 : addr_mem[rd_ptr[PTR_W-1:0]];

  // Storage, pointers and the sticky overflow flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
      for (int k = 0; k < FIFO_DEPTH; k++) begin
        tile_mem[k] <= '0;
        addr_mem[k] <= '0;
      end
    end else begin
      if (do_push) begin
        tile_mem[wr_ptr[PTR_W-1:0]] <= push_tile;
        addr_mem[wr_ptr[PTR_W-1:0]] <= push_addr;
        wr_ptr <= wr_ptr + (PTR_W + 1)'(1);
      end
      if (pop)
        rd_ptr <= rd_ptr + (PTR_W + 1)'(1);
      if (push && full && !pop)
        overflow <= 1'b1;
    end
  end

endmodule

// File: rtl/winograd_pe_acc.sv
// Systolic Winograd processing element with transform-domain accumulation.
// Data tiles arrive from above and weight tiles from the left; both are
// registered and forwarded. Matching beats are multiplied elementwise and
// accumulated over input channels; the last beat triggers the AT*M*A output
// transform and the finished tile is pushed into a small show-ahead FIFO.
// Ports:
//   clk, reset                          - clock, asynchronous active-high reset
//   data_*_i / data_*_o                 - data tile path, registered pass-down
//   size_type_i/o, block_cnt_i/o        - combinational pass-down
//   weight_*_i / weight_*_o             - weight tile path, registered pass-right
//   result_tile_o, result_address_o,
//   result_valid_o, result_ready_i      - FIFO head and ready/valid drain
//   overflow_o                          - sticky, a finished tile was dropped
module winograd_pe_acc
  import winograd_pkg::*;
#(
  parameter int DATA_W     = 14,
  parameter int WEIGHT_W   = 12,
  parameter int PROD_SHIFT = 7,
  parameter int ACC_W      = 20,
  parameter int OUT_SHIFT  = 4,
  parameter int OUT_W      = 16,
  parameter int ADDR_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [5:0][5:0][DATA_W-1:0]   data_tile_i,
  input  logic                          data_valid_i,
  input  logic                          data_last_i,
  input  logic [ADDR_W-1:0]             data_addr_i,
  input  logic                          size_type_i,
  input  logic [ADDR_W-1:0]             block_cnt_i,
  input  logic [5:0][5:0][WEIGHT_W-1:0] weight_tile_i,
  input  logic                          weight_valid_i,
  input  logic [ADDR_W-1:0]             weight_od_i,
  output logic [5:0][5:0][DATA_W-1:0]   data_tile_o,
  output logic                          data_valid_o,
  output logic                          data_last_o,
  output logic [ADDR_W-1:0]             data_addr_o,
  output logic                          size_type_o,
  output logic [ADDR_W-1:0]             block_cnt_o,
  output logic [5:0][5:0][WEIGHT_W-1:0] weight_tile_o,
  output logic                          weight_valid_o,
  output logic [ADDR_W-1:0]             weight_od_o,
  output logic [5:0][5:0][OUT_W-1:0]    result_tile_o,
  output logic [ADDR_W-1:0]             result_address_o,
  output logic                          result_valid_o,
  input  logic                          result_ready_i,
  output logic                          overflow_o
);

  localparam int PW = DATA_W + WEIGHT_W;
  localparam int TW = ACC_W + 6;

  logic                        beat;
  logic [ADDR_W-1:0]           beat_addr;
  logic [5:0][5:0][ACC_W-1:0]  acc_q;
  logic [5:0][5:0][ACC_W-1:0]  acc_next;
  logic                        open_q;
  mode_e                       mode_q;
  logic [ADDR_W-1:0]           acc_addr_q;
  logic                        s3_valid;
  logic [5:0][5:0][TW-1:0]     t_q;
  logic [5:0][5:0][TW-1:0]     t_next;
  mode_e                       t_mode_q;
  logic [ADDR_W-1:0]           t_addr_q;
  logic                        t_valid_q;
  logic [5:0][5:0][OUT_W-1:0]  r_tile;

  // Held at 0 during reset so every output reads 0 while reset is asserted.
  assign size_type_o = reset ? 1'b0 : size_type_i;
  assign block_cnt_o = reset ? '0 : block_cnt_i;

  assign beat      = data_valid_o & weight_valid_o;
  assign beat_addr = weight_od_o * block_cnt_o + data_addr_o;

  // Data neighbour register; an invalid beat forwards zeros.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_tile_o  <= '0;
      data_valid_o <= 1'b0;
      data_last_o  <= 1'b0;
      data_addr_o  <= '0;
    end else begin
      data_valid_o <= data_valid_i;
      data_tile_o  <= data_valid_i ? data_tile_i : '0;
      data_last_o  <= data_valid_i & data_last_i;
      data_addr_o  <= data_valid_i ? data_addr_i : '0;
    end
  end

  // Weight neighbour register, independent of the data path.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      weight_tile_o  <= '0;
      weight_valid_o <= 1'b0;
      weight_od_o    <= '0;
    end else begin
      weight_valid_o <= weight_valid_i;
      weight_tile_o  <= weight_valid_i ? weight_tile_i : '0;
      weight_od_o    <= weight_valid_i ? weight_od_i : '0;
    end
  end

  // Elementwise product and saturating accumulate; a closed accumulator restarts from zero.
  always_comb begin
    acc_next = acc_q;
    for (int i = 0; i < 6; i++) begin
      for (int j = 0; j < 6; j++) begin
        logic signed [PW-1:0] prod;
        wide_t                base;
        prod = PW'($signed(data_tile_o[i][j])) * PW'($signed(weight_tile_o[i][j]));
        base = open_q ? 64'($signed(acc_q[i][j])) : 64'sd0;
        acc_next[i][j] = ACC_W'(sat(base + 64'(prod >>> PROD_SHIFT), ACC_W));
      end
    end
  end

  // Accumulator state; mode is captured on the opening beat, address on the closing one.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q      <= '0;
      open_q     <= 1'b0;
      mode_q     <= MODE_6X6;
      acc_addr_q <= '0;
      s3_valid   <= 1'b0;
    end else begin
      s3_valid <= beat & data_last_o;
      if (beat) begin
        acc_q  <= acc_next;
        open_q <= !data_last_o;
        if (!open_q)
          mode_q <= mode_e'(size_type_o);
        if (data_last_o)
          acc_addr_q <= beat_addr;
      end
    end
  end

  // Left half of the output transform: T = AT * acc, column by column.
  always_comb begin
    t_next = '0;
    for (int c = 0; c < 6; c++) begin
      vec6_t col;
      col = '0;
      for (int k = 0; k < 6; k++)
        col[k] = 64'($signed(acc_q[k][c]));
      for (int r = 0; r < 6; r++)
        t_next[r][c] = TW'(at_row(col, r, mode_q == MODE_4X4));
    end
  end

  // Transform stage register; carries mode and address alongside T.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      t_q       <= '0;
      t_mode_q  <= MODE_6X6;
      t_addr_q  <= '0;
      t_valid_q <= 1'b0;
    end else begin
      t_valid_q <= s3_valid;
      if (s3_valid) begin
        t_q      <= t_next;
        t_mode_q <= mode_q;
        t_addr_q <= acc_addr_q;
      end
    end
  end

  // Right half: R = sat((T * A) >>> OUT_SHIFT); row r of T*A uses AT rows as columns.
  // In 4x4 mode only the top-left 4x4 of R is meaningful; the rest is zeroed.
  always_comb begin
    r_tile = '0;
    for (int r = 0; r < 6; r++) begin
      vec6_t row;
      row = '0;
      for (int k = 0; k < 6; k++)
        row[k] = 64'($signed(t_q[r][k]));
      for (int c = 0; c < 6; c++) begin
        if (!(t_mode_q == MODE_4X4 && (r >= 4 || c >= 4)))
          r_tile[r][c] = OUT_W'(sat(at_row(row, c, t_mode_q == MODE_4X4) >>> OUT_SHIFT, OUT_W));
      end
    end
  end

  winograd_out_fifo #(
    .ELEM_W     (OUT_W),
    .ADDR_W     (ADDR_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_out_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (t_valid_q),
    .push_tile  (r_tile),
    .push_addr  (t_addr_q),
    .pop_ready  (result_ready_i),
    .head_tile  (result_tile_o),
    .head_addr  (result_address_o),
    .head_valid (result_valid_o),
    .overflow   (overflow_o)
  );

endmodule
